// File: rtl/register_file_sb.sv
// NRD-port register file with a per-register scoreboard of in-flight writes and per-port stall.
// Define REGFILE_FWD_EN to enable EXE/WB bypass; without it reads come only from the array.
module register_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 16,
  parameter int NRD      = 4,
  parameter int MAX_PEND = 3,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_stall,
  output logic                stall,
  output logic                fwd_used,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  input  logic                exe_fwd_valid,
  input  logic [AW-1:0]       exe_fwd_addr,
  input  logic [XLEN-1:0]     exe_fwd_data,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic                sb_err
);

  localparam int CW = $clog2(MAX_PEND + 1);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CW-1:0]    r_pend [NREGS];
  logic             r_sb_err;
  logic             w_iss_fire;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;

`ifndef REGFILE_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exe_fwd_valid, exe_fwd_addr, exe_fwd_data};
`endif

  // Read ports: zero-latency data select and hazard evaluation
  always_comb begin
    logic [AW-1:0] w_addr;
    logic [CW-1:0] w_cnt;
`ifdef REGFILE_FWD_EN
    logic          w_exe_hit;
    logic          w_wb_hit;
    logic          w_ok_exe;
    logic          w_ok_wb;
    logic [CW:0]   w_need;
`endif
    rd_data  = '0;
    rd_stall = '0;
    fwd_used = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      w_addr = rd_addr[p*AW +: AW];
      w_cnt  = r_pend[w_addr];
`ifdef REGFILE_FWD_EN
      w_exe_hit = exe_fwd_valid && (exe_fwd_addr == w_addr) && (w_addr != '0);
      w_wb_hit  = wb_valid && (wb_addr == w_addr) && (w_addr != '0);
      // A bypass only resolves the hazard when it carries the youngest pending write
      w_need    = {{CW{1'b0}}, 1'b1} + {{CW{1'b0}}, w_wb_hit};
      w_ok_exe  = w_exe_hit && ({1'b0, w_cnt} == w_need);
      w_ok_wb   = w_wb_hit && !w_exe_hit && (w_cnt == CW'(1));
      if (w_addr == '0)
        rd_data[p*XLEN +: XLEN] = '0;
      else if (w_exe_hit)
        rd_data[p*XLEN +: XLEN] = exe_fwd_data;
      else if (w_wb_hit)
        rd_data[p*XLEN +: XLEN] = wb_data;
      else
        rd_data[p*XLEN +: XLEN] = r_regs[w_addr];
      rd_stall[p] = rd_en[p] && (w_cnt != '0) && !(w_ok_exe || w_ok_wb);
      if (rd_en[p] && w_exe_hit)
        fwd_used = 1'b1;
`else
      rd_data[p*XLEN +: XLEN] = (w_addr == '0) ? '0 : r_regs[w_addr];
      rd_stall[p] = rd_en[p] && (w_cnt != '0);
`endif
    end
  end

  assign stall      = |rd_stall;
  assign iss_ready  = (r_pend[iss_addr] != CW'(MAX_PEND));
  assign w_iss_fire = iss_valid && iss_ready && !stall;
  assign sb_err     = r_sb_err;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_inc[i] = w_iss_fire && (iss_addr == AW'(i));
      w_dec[i] = wb_valid && (wb_addr == AW'(i));
    end
  end

  // Array write and scoreboard update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      if (wb_valid && (wb_addr != '0)) begin
        r_regs[wb_addr] <= wb_data;
        if (r_pend[wb_addr] == '0)
          r_sb_err <= 1'b1;
      end
      for (int i = 0; i < NREGS; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_pend[i] <= r_pend[i] + CW'(1);
        else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0))
          r_pend[i] <= r_pend[i] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb; expectations adapt to whether REGFILE_FWD_EN is defined.
module tb_register_file_sb;
  localparam int XLEN = 32, NREGS = 16, NRD = 4, MAX_PEND = 3, AW = 4;
`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_stall;
  logic                stall, fwd_used, iss_valid, iss_ready;
  logic [AW-1:0]       iss_addr, exe_fwd_addr, wb_addr;
  logic                exe_fwd_valid, wb_valid, sb_err;
  logic [XLEN-1:0]     exe_fwd_data, wb_data;
  logic [XLEN-1:0]     exp_d;
  logic [NRD*XLEN-1:0] exp_v;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_stall(rd_stall), .stall(stall), .fwd_used(fwd_used), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_ready(iss_ready), .exe_fwd_valid(exe_fwd_valid),
    .exe_fwd_addr(exe_fwd_addr), .exe_fwd_data(exe_fwd_data), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .sb_err(sb_err)
  );

  task automatic idle();
    rd_en = '0; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    exe_fwd_valid = 1'b0; exe_fwd_addr = '0; exe_fwd_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] port_data(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic test_reset();
    idle();
    wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 32'hAAAA_5555;
    iss_valid = 1'b1; iss_addr = 4'd2;
    tick();
    idle();
    rd_en = 4'hF; rd_addr = {4'd2, 4'd2, 4'd1, 4'd1}; iss_addr = 4'd2;
    #1;
    n_tests++; if (port_data(0) !== 32'hAAAA_5555) begin n_fail++; $display("FAIL pre_rst_data: got %h need %h", port_data(0), 32'hAAAA_5555); end
    n_tests++; if (rd_stall !== 4'b1100) begin n_fail++; $display("FAIL pre_rst_stall: got %b need %b", rd_stall, 4'b1100); end
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL pre_rst_sb_err: got %b need 1", sb_err); end
    rst = 1'b1;
    #1;
    n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h need 0", rd_data); end
    n_tests++; if (rd_stall !== 4'b0000 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b/%b need 0000/0", rd_stall, stall); end
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL rst_iss_ready: got %b need 1", iss_ready); end
    n_tests++; if (sb_err !== 1'b0 || fwd_used !== 1'b0) begin n_fail++; $display("FAIL rst_sb_err_fwd: got %b/%b need 0/0", sb_err, fwd_used); end
    tick();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_fwd();
    idle();
    iss_valid = 1'b1; iss_addr = 4'd3;
    #1;
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_iss_ready: got %b need 1", iss_ready); end
    tick();
    idle();
    rd_en = 4'b0001; rd_addr = 16'h0003;
    exe_fwd_valid = 1'b1; exe_fwd_addr = 4'd3; exe_fwd_data = 32'hDEAD_BEEF;
    #1;
    exp_d = FWD ? 32'hDEAD_BEEF : 32'h0;
    n_tests++; if (port_data(0) !== exp_d) begin n_fail++; $display("FAIL fwd_exe_data: got %h need %h", port_data(0), exp_d); end
    n_tests++; if (fwd_used !== FWD) begin n_fail++; $display("FAIL fwd_used: got %b need %b", fwd_used, FWD); end
    n_tests++; if (rd_stall !== {3'b000, !FWD}) begin n_fail++; $display("FAIL fwd_exe_stall: got %b need %b", rd_stall, {3'b000, !FWD}); end
    exe_fwd_valid = 1'b0;
    #1;
    n_tests++; if (rd_stall !== 4'b0001 || stall !== 1'b1) begin n_fail++; $display("FAIL fwd_none_stall: got %b/%b need 0001/1", rd_stall, stall); end
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (port_data(0) !== exp_d) begin n_fail++; $display("FAIL fwd_wb_data: got %h need %h", port_data(0), exp_d); end
    n_tests++; if (stall !== !FWD) begin n_fail++; $display("FAIL fwd_wb_stall: got %b need %b", stall, !FWD); end
    tick();
    idle();
    rd_en = 4'b0001; rd_addr = 16'h0003;
    #1;
    n_tests++; if (port_data(0) !== 32'hDEAD_BEEF || stall !== 1'b0) begin n_fail++; $display("FAIL fwd_landed: got %h/%b need deadbeef/0", port_data(0), stall); end
  endtask

  task automatic test_youngest();
    idle();
    iss_valid = 1'b1; iss_addr = 4'd5;
    tick();
    tick();
    idle();
    rd_en = 4'b0001; rd_addr = 16'h0005;
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h11;
    exe_fwd_valid = 1'b1; exe_fwd_addr = 4'd5; exe_fwd_data = 32'h22;
    #1;
    exp_d = FWD ? 32'h22 : 32'h0;
    n_tests++; if (port_data(0) !== exp_d) begin n_fail++; $display("FAIL young_exe_data: got %h need %h", port_data(0), exp_d); end
    n_tests++; if (stall !== !FWD) begin n_fail++; $display("FAIL young_exe_stall: got %b need %b", stall, !FWD); end
    exe_fwd_valid = 1'b0;
    #1;
    exp_d = FWD ? 32'h11 : 32'h0;
    n_tests++; if (port_data(0) !== exp_d) begin n_fail++; $display("FAIL young_wb_data: got %h need %h", port_data(0), exp_d); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL young_wb_stall: got %b need 1", stall); end
    tick();
    wb_data = 32'h33;
    #1;
    exp_d = FWD ? 32'h33 : 32'h11;
    n_tests++; if (port_data(0) !== exp_d) begin n_fail++; $display("FAIL young_cnt1_data: got %h need %h", port_data(0), exp_d); end
    n_tests++; if (stall !== !FWD) begin n_fail++; $display("FAIL young_cnt1_stall: got %b need %b", stall, !FWD); end
    tick();
    idle();
    rd_en = 4'b0001; rd_addr = 16'h0005;
    #1;
    n_tests++; if (port_data(0) !== 32'h33 || stall !== 1'b0) begin n_fail++; $display("FAIL young_drained: got %h/%b need 33/0", port_data(0), stall); end
  endtask

  task automatic test_max_pend();
    idle();
    iss_valid = 1'b1; iss_addr = 4'd7;
    for (int k = 0; k < MAX_PEND; k++) begin
      #1;
      n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL max_ready_%0d: got %b need 1", k, iss_ready); end
      tick();
    end
    #1;
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_full: got %b need 0", iss_ready); end
    tick();
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_hold: got %b need 0", iss_ready); end
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
    tick();
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL max_after_wb: got %b need 1", iss_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL max_same_cycle: got %b need 1", iss_ready); end
    tick();
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_refill: got %b need 0", iss_ready); end
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_data = 32'h78;
    for (int k = 0; k < MAX_PEND; k++) tick();
    idle();
    iss_addr = 4'd7; rd_en = 4'b0001; rd_addr = 16'h0007;
    #1;
    n_tests++; if (iss_ready !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL max_drained: got %b/%b need 1/0", iss_ready, stall); end
    n_tests++; if (port_data(0) !== 32'h78 || sb_err !== 1'b0) begin n_fail++; $display("FAIL max_data_err: got %h/%b need 78/0", port_data(0), sb_err); end
  endtask

  task automatic test_r0();
    idle();
    rd_en = 4'hF; rd_addr = '0;
    exe_fwd_valid = 1'b1; exe_fwd_addr = 4'd0; exe_fwd_data = 32'hFFFF_FFFF;
    wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 4'd0;
    #1;
    n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL r0_data: got %h need 0", rd_data); end
    n_tests++; if (rd_stall !== 4'b0000 || fwd_used !== 1'b0) begin n_fail++; $display("FAIL r0_stall_fwd: got %b/%b need 0000/0", rd_stall, fwd_used); end
    for (int k = 0; k < MAX_PEND; k++) tick();
    exe_fwd_valid = 1'b0; wb_valid = 1'b0;
    #1;
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL r0_count: got %b need 1", iss_ready); end
    n_tests++; if (rd_data !== '0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL r0_after: got %h/%b need 0/0", rd_data, sb_err); end
    idle();
  endtask

  task automatic test_multi_port();
    idle();
    iss_valid = 1'b1; iss_addr = 4'd5;
    tick();
    idle();
    rd_en = 4'hF; rd_addr = {4'd0, 4'd7, 4'd5, 4'd3};
    exe_fwd_valid = 1'b1; exe_fwd_addr = 4'd7; exe_fwd_data = 32'h0BAD_F00D;
    #1;
    exp_v = {32'h0, (FWD ? 32'h0BAD_F00D : 32'h78), 32'h33, 32'hDEAD_BEEF};
    n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL mp_data: got %h need %h", rd_data, exp_v); end
    n_tests++; if (rd_stall !== 4'b0010 || fwd_used !== FWD) begin n_fail++; $display("FAIL mp_stall_fwd: got %b/%b need 0010/%b", rd_stall, fwd_used, FWD); end
    rd_en = 4'b1101;
    #1;
    n_tests++; if (rd_stall !== 4'b0000 || stall !== 1'b0) begin n_fail++; $display("FAIL mp_gated: got %b/%b need 0000/0", rd_stall, stall); end
    idle();
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h55;
    tick();
    idle();
  endtask

  task automatic test_underflow();
    idle();
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h99;
    #1;
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL uf_before: got %b need 0", sb_err); end
    tick();
    idle();
    rd_en = 4'b0001; rd_addr = 16'h0009;
    #1;
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b need 1", sb_err); end
    n_tests++; if (port_data(0) !== 32'h99 || stall !== 1'b0) begin n_fail++; $display("FAIL uf_written: got %h/%b need 99/0", port_data(0), stall); end
    tick();
    tick();
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b need 1", sb_err); end
    idle();
    iss_valid = 1'b1; iss_addr = 4'd4;
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL uf_rst_clear: got %b need 0", sb_err); end
    tick();
    rst = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
    tick();
    idle();
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL uf_stale_wb: got %b need 1", sb_err); end
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fwd();
    test_youngest();
    test_max_pend();
    test_r0();
    test_multi_port();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
